// File: rtl/satalnk_txsched.sv
// Transmit link scheduler: one TX dword slot shared by ALIGN pairs, link primitives and frame data.
// Build option SATA_CONT_EN enables CONT compression of repeated primitives.
module satalnk_txsched #(
    parameter int ALIGN_INTERVAL = 254,
    parameter int LGALIGN        = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_prim_valid,
    input  logic [31:0] i_prim,
    input  logic        i_data_valid,
    output logic        o_data_ready,
    input  logic [31:0] i_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_primitive,
    output logic [31:0] o_data,
    output logic [1:0]  o_dbg_state
);

    localparam logic [31:0] P_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] P_CONT  = 32'h9999_AA7C;
    localparam logic [LGALIGN-1:0] ALIGN_LIMIT = LGALIGN'(ALIGN_INTERVAL);

    typedef enum logic [1:0] {
        S_NORMAL = 2'd0,
        S_ALIGN0 = 2'd1,
        S_ALIGN1 = 2'd2
    } state_t;

    state_t             state;
    logic [LGALIGN-1:0] align_count;
    logic [LGALIGN-1:0] align_count_inc;
    logic               advance;
    logic               align_due;
    logic               align_hit;
    logic [31:0]        prim_word;
    logic               prim_flag;
    logic               prim_is_align;

    // Handshake: a dword transfers on any edge where o_valid && i_ready. The
    // output register reloads whenever it is empty or being drained (advance);
    // otherwise it holds. o_data_ready marks the edge at which i_data is taken.
    assign advance         = !o_valid || i_ready;
    assign align_due       = (align_count == ALIGN_LIMIT);
    assign align_count_inc = align_count + LGALIGN'(1);
    assign align_hit       = (align_count_inc == ALIGN_LIMIT);
    assign prim_is_align   = prim_flag && (prim_word == P_ALIGN);
    assign o_data_ready    = advance && (state == S_NORMAL) && !i_prim_valid && !align_due;
    assign o_dbg_state     = state;

`ifdef SATA_CONT_EN
    logic [1:0]  rep_count;
    logic [1:0]  rep_next;
    logic [31:0] r_last;
    logic [31:0] lfsr;
    logic [31:0] lfsr_step;
    logic        last_load;
    logic        lfsr_adv;

    // x^32 + x^22 + x^2 + x + 1, shifting toward the MSB.
    assign lfsr_step = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

    always_comb begin
        prim_word = i_prim;
        prim_flag = 1'b1;
        rep_next  = 2'd1;
        last_load = 1'b0;
        lfsr_adv  = 1'b0;
        if (i_prim == P_ALIGN || i_prim == P_CONT) begin
            rep_next = 2'd0;
        end else if (i_prim != r_last || rep_count == 2'd0) begin
            last_load = 1'b1;
        end else if (rep_count == 2'd1) begin
            rep_next = 2'd2;
        end else if (rep_count == 2'd2) begin
            prim_word = P_CONT;
            rep_next  = 2'd3;
        end else begin
            prim_word = lfsr_step;
            prim_flag = 1'b0;
            rep_next  = 2'd3;
            lfsr_adv  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rep_count <= 2'd0;
            r_last    <= 32'h0;
            lfsr      <= 32'h0000_0001;
        end else if (advance) begin
            if (state == S_ALIGN1) begin
                rep_count <= 2'd0;
            end else if (state == S_NORMAL) begin
                if (i_prim_valid) begin
                    rep_count <= rep_next;
                    if (last_load)
                        r_last <= i_prim;
                    if (lfsr_adv)
                        lfsr <= lfsr_step;
                end else if (i_data_valid) begin
                    rep_count <= 2'd0;
                end
            end
        end
    end
`else
    always_comb begin
        prim_word = i_prim;
        prim_flag = 1'b1;
    end
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_NORMAL;
            align_count <= '0;
            o_valid     <= 1'b0;
            o_primitive <= 1'b0;
            o_data      <= 32'h0;
        end else if (advance) begin
            case (state)
                S_ALIGN0: begin
                    o_valid     <= 1'b1;
                    o_primitive <= 1'b1;
                    o_data      <= P_ALIGN;
                    state       <= S_ALIGN1;
                end
                S_ALIGN1: begin
                    o_valid     <= 1'b1;
                    o_primitive <= 1'b1;
                    o_data      <= P_ALIGN;
                    align_count <= '0;
                    state       <= S_NORMAL;
                end
                default: begin
                    // The pair is armed as the interval's last dword is loaded, so it follows back-to-back.
                    if (i_prim_valid) begin
                        o_valid     <= 1'b1;
                        o_primitive <= prim_flag;
                        o_data      <= prim_word;
                        if (!prim_is_align) begin
                            align_count <= align_count_inc;
                            if (align_hit)
                                state <= S_ALIGN0;
                        end
                    end else if (i_data_valid && !align_due) begin
                        o_valid     <= 1'b1;
                        o_primitive <= 1'b0;
                        o_data      <= i_data;
                        align_count <= align_count_inc;
                        if (align_hit)
                            state <= S_ALIGN0;
                    end else begin
                        o_valid     <= 1'b0;
                        o_primitive <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
